wb_queue: RTL
=============

Name: wb_queue

Overview:
- Write-back sequencer for the 20-bit MIPS datapath; the writer side of the 8x20 register file.
- Accepts result writes from the execute/memory units through a valid/ready handshake and buffers them in order.
- Drives the register file write port (reg_write, write_register, write_data), at most one write per clock.
- Provides a combinational lookup so decode/forwarding logic can find results still pending in the queue.

Parameters:
- DEPTH, 4, number of FIFO entries behind the output stage (power of two, >= 2)
- DATA_W, 20, data word width
- ADDR_W, 3, register address width (8 registers)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous reset, active-high
- wb_valid  input  1  producer has a result to write
- wb_ready  output  1  queue can accept this cycle
- wb_reg  input  ADDR_W  destination register of the offered result
- wb_data  input  DATA_W  result value
- hold  input  1  pauses draining into the register file
- reg_write  output  1  register file write enable (registered)
- write_register  output  ADDR_W  register file write address (registered)
- write_data  output  DATA_W  register file write data (registered)
- lookup_reg  input  ADDR_W  register number being queried
- lookup_hit  output  1  a pending write to lookup_reg exists
- lookup_data  output  DATA_W  value of the youngest pending write to lookup_reg; 0 when no hit
- count  output  clog2(DEPTH)+1  number of FIFO entries held (excludes the output stage)

Behaviour:
- One clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - count=0, FIFO pointers=0, reg_write=0, write_register=0, write_data=0.
  - FIFO contents are not reset.
  - Reset wins over every simultaneous event; in-flight and buffered writes are discarded, including any entry in the output stage.
- Handshake:
  - wb_ready = (count < DEPTH). It depends on registered state only, not on wb_valid or hold.
  - A transfer occurs on a posedge where wb_valid && wb_ready.
  - The producer holds wb_reg/wb_data stable while wb_valid=1 && wb_ready=0.
- Output stage (reg_write/write_register/write_data):
  - It is consumed by the register file on every edge where reg_write=1, so each entry appears for exactly one cycle.
  - At each posedge with hold=0:
    - if count>0: load the FIFO head, reg_write<=1, pop;
    - else if a transfer is occurring: load wb_reg/wb_data directly (bypass, no FIFO push), reg_write<=1;
    - else reg_write<=0.
  - At each posedge with hold=1: reg_write<=0, no pop, no bypass. Transfers still push into the FIFO if wb_ready.
- Latency: with an empty queue and hold=0, a result accepted at edge N is driven with reg_write=1 during cycle N..N+1 and is written into the register file at edge N+1.
- Simultaneous push and pop with count>0: the head is popped and the new entry is pushed; count is unchanged. This is legal when count=DEPTH only if wb_ready was already 1, which it was not, so a full queue never accepts.
- count: +1 on push without pop, -1 on pop without push, otherwise unchanged. Bypass changes nothing.
- Pointers: ADDR width of clog2(DEPTH) and wrap modulo DEPTH.
- Ordering:
  - Strict FIFO order.
  - Back-to-back writes to the same register reach the register file in acceptance order, so the last accepted value wins.
- Register 0 is an ordinary writable register; there is no zero-register suppression.
- Lookup (combinational):
  - Searches, youngest first, the valid FIFO entries (tail-1 back to head) and then the output stage if reg_write=1.
  - The first match gives lookup_hit=1 and lookup_data=that entry.
  - An incoming, not-yet-accepted wb_* value is never matched.
- Reset mid-operation: the next cycle shows reg_write=0, count=0, wb_ready=1 and lookup_hit=0 for all registers.

Test Plan:
- Reset then single write: wb_valid=1, wb_reg=3, wb_data=20'h0000A at edge 1 -> reg_write=1, write_register=3, write_data=20'h0000A in cycle 1-2 only; count stays 0.
- Fill under hold: hold=1, push regs 1,2,3,4 with data 11,22,33,44 -> count=4, wb_ready=0, a fifth push is refused. Release hold -> writes appear on 4 consecutive cycles in order 1/11, 2/22, 3/33, 4/44.
- Simultaneous push/pop: count=2, hold=0, push reg 5/data 55 -> count stays 2, head emitted, 5/55 emitted two cycles later.
- Lookup priority: under hold, push reg 6/data 7 then reg 6/data 9 -> lookup_reg=6 gives hit=1, data=9; lookup_reg=2 gives hit=0, data=0. After the first drain, data=9 still.
- Pointer wrap: 3*DEPTH+1 pushes with interleaved hold toggling -> output sequence identical to input sequence, no loss or duplication.
- Reset mid-drain: count=3, reg_write=1, assert rst one cycle -> next cycle reg_write=0, count=0, wb_ready=1, lookup_hit=0; no further writes emitted.

Source files
------------

// File: rtl/wb_queue.sv
// Write-back sequencer: buffers execute/memory results in order and drives the 8x20 register file write port.
// Latency: with an empty queue and hold low, a result accepted at edge N is on the write port during cycle N..N+1.
// Backpressure: wb_ready = (count < DEPTH), taken from registered state only; hold pauses draining but not accepting.
//
// Ports: clk/rst (synchronous, active-high); wb_valid/wb_ready/wb_reg/wb_data producer handshake;
//        hold pauses the output stage; reg_write/write_register/write_data registered RF write port;
//        lookup_reg -> lookup_hit/lookup_data combinational youngest-first pending-write search;
//        count = FIFO occupancy, not counting the output stage.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 20,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [ADDR_W-1:0]      wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   hold,
    output logic                   reg_write,
    output logic [ADDR_W-1:0]      write_register,
    output logic [DATA_W-1:0]      write_data,
    input  logic [ADDR_W-1:0]      lookup_reg,
    output logic                   lookup_hit,
    output logic [DATA_W-1:0]      lookup_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage; contents deliberately not reset, validity comes from count_q.
    logic [ADDR_W-1:0] reg_mem_q [DEPTH];
    logic [DATA_W-1:0] dat_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;

    logic              xfer;
    logic              fifo_nonempty;
    logic              pop;
    logic              push;
    logic [PTR_W-1:0]  idx;

    assign wb_ready      = (count_q < CNT_W'(DEPTH));
    assign xfer          = wb_valid && wb_ready;
    assign fifo_nonempty = (count_q != '0);
    assign pop           = !hold && fifo_nonempty;
    // An accepted result skips the FIFO only when the output stage can take it
    // directly and nothing older is waiting; otherwise it is queued.
    assign push          = xfer && (hold || fifo_nonempty);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rw_d     = 1'b0;
        wreg_d   = wreg_q;
        wdat_d   = wdat_q;

        if (pop) begin
            rw_d     = 1'b1;
            wreg_d   = reg_mem_q[rd_ptr_q];
            wdat_d   = dat_mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (!hold && xfer) begin
            rw_d   = 1'b1;
            wreg_d = wb_reg;
            wdat_d = wb_data;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rw_q     <= 1'b0;
            wreg_q   <= '0;
            wdat_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rw_q     <= rw_d;
            wreg_q   <= wreg_d;
            wdat_q   <= wdat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem_q[wr_ptr_q] <= wb_reg;
            dat_mem_q[wr_ptr_q] <= wb_data;
        end
    end

    // Walk oldest to youngest (output stage first, then head..tail-1) so the
    // last match, i.e. the youngest pending write, is what remains.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = rd_ptr_q;
        if (rw_q && (wreg_q == lookup_reg)) begin
            lookup_hit  = 1'b1;
            lookup_data = wdat_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (reg_mem_q[idx] == lookup_reg)) begin
                lookup_hit  = 1'b1;
                lookup_data = dat_mem_q[idx];
            end
        end
    end

    assign reg_write      = rw_q;
    assign write_register = wreg_q;
    assign write_data     = wdat_q;
    assign count          = count_q;

endmodule
